// File: rtl/pong_match_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : pong_match_fsm
//  Description : Match-flow controller for Pong, 2..4 players. Tracks per-player
//                scores, ends the match at WIN_SCORE or on time_up, inserts a
//                tick-counted serve delay and reports winner/tie on entry to OVER.
//                Optional build macro PONG_MATCH_PAUSE_EN adds a start-button
//                pause hold while in PLAY.
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_match_fsm #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_TICKS = 200
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           tick,
  input  logic                           time_up,
  input  logic [NUM_PLAYERS-1:0]         miss,
  output logic [1:0]                     state,
  output logic                           stop,
  output logic                           timer_run,
  output logic                           serve,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [1:0]                     winner,
  output logic                           tie
);

  localparam int                 CNT_W        = (SERVE_TICKS < 1) ? 1 : $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0]   C_SERVE_LOAD = CNT_W'(SERVE_TICKS);
  localparam logic [SCORE_W-1:0] C_SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] C_WIN        = SCORE_W'(WIN_SCORE);
  localparam int                 SV_W         = NUM_PLAYERS * SCORE_W;

  // PAUSE lives outside the 2-bit reported range and is shown as state 1.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_OVER  = 3'd3,
    ST_PAUSE = 3'd4
  } st_t;

  st_t              st_q, st_d;
  logic [SV_W-1:0]  score_q, score_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             serve_q, serve_d;
  logic [1:0]       winner_q, winner_d;
  logic             tie_q, tie_d;
  logic             start_prev_q;

  logic             start_edge;
  logic             miss_single;
  logic             miss_multi;
  logic [SV_W-1:0]  bumped;
  logic [NUM_PLAYERS-1:0] hit;
  logic             win_hit;
  logic [SV_W-1:0]  eval_scores;
  logic [1:0]       eval_winner;
  logic             eval_tie;

  assign start_edge = start & ~start_prev_q;

  // A lone miss bit awards points; several at once void the rally.
  assign miss_single = (miss != '0) && ((miss & (miss - NUM_PLAYERS'(1))) == '0);
  assign miss_multi  = (miss != '0) && !miss_single;

  // Every player that did not miss gains one point, saturating at the counter top.
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_bump
    logic [SCORE_W-1:0] cur;
    logic [SCORE_W-1:0] nxt;
    assign cur = score_q[g*SCORE_W +: SCORE_W];
    assign nxt = (miss[g] || (cur == C_SCORE_MAX)) ? cur : cur + SCORE_W'(1);
    assign bumped[g*SCORE_W +: SCORE_W] = nxt;
    assign hit[g] = (nxt >= C_WIN);
  end

  assign win_hit = |hit;

  // time_up outranks a miss, so the result is judged on unchanged scores then.
  assign eval_scores = time_up ? score_q : (miss_single ? bumped : score_q);

  // Lowest index with the top score wins; tie when the top score is shared.
  always_comb begin
    logic [SCORE_W-1:0] top;
    logic [2:0]         n_top;
    top         = eval_scores[0 +: SCORE_W];
    eval_winner = 2'd0;
    n_top       = 3'd0;
    for (int i = 1; i < NUM_PLAYERS; i++) begin
      if (eval_scores[i*SCORE_W +: SCORE_W] > top) begin
        top         = eval_scores[i*SCORE_W +: SCORE_W];
        eval_winner = 2'(i);
      end
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (eval_scores[i*SCORE_W +: SCORE_W] == top) begin
        n_top = n_top + 3'd1;
      end
    end
    eval_tie = (n_top > 3'd1);
  end

  // Next-state, score, serve-counter and result computation.
  always_comb begin
    st_d     = st_q;
    score_d  = score_q;
    cnt_d    = cnt_q;
    serve_d  = 1'b0;
    winner_d = winner_q;
    tie_d    = tie_q;
    case (st_q)
      ST_IDLE: begin
        if (start_edge) begin
          score_d = '0;
          cnt_d   = C_SERVE_LOAD;
          st_d    = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (time_up) begin
          st_d     = ST_OVER;
          winner_d = eval_winner;
          tie_d    = eval_tie;
        end else if (cnt_q == '0) begin
          st_d    = ST_PLAY;
          serve_d = 1'b1;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PLAY: begin
        if (time_up) begin
          st_d     = ST_OVER;
          winner_d = eval_winner;
          tie_d    = eval_tie;
        end else if (miss_single) begin
          score_d = bumped;
          if (win_hit) begin
            st_d     = ST_OVER;
            winner_d = eval_winner;
            tie_d    = eval_tie;
          end else begin
            cnt_d = C_SERVE_LOAD;
            st_d  = ST_SERVE;
          end
        end else if (miss_multi) begin
          cnt_d = C_SERVE_LOAD;
          st_d  = ST_SERVE;
        end
`ifdef PONG_MATCH_PAUSE_EN
        else if (start_edge) begin
          st_d = ST_PAUSE;
        end
`endif
      end
`ifdef PONG_MATCH_PAUSE_EN
      ST_PAUSE: begin
        if (time_up) begin
          st_d     = ST_OVER;
          winner_d = eval_winner;
          tie_d    = eval_tie;
        end else if (start_edge) begin
          st_d = ST_PLAY;
        end
      end
`endif
      ST_OVER: begin
        if (start_edge) begin
          st_d     = ST_IDLE;
          winner_d = 2'd0;
          tie_d    = 1'b0;
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q         <= ST_IDLE;
      score_q      <= '0;
      cnt_q        <= '0;
      serve_q      <= 1'b0;
      winner_q     <= 2'd0;
      tie_q        <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      score_q      <= score_d;
      cnt_q        <= cnt_d;
      serve_q      <= serve_d;
      winner_q     <= winner_d;
      tie_q        <= tie_d;
      start_prev_q <= start;
    end
  end

  assign state     = (st_q == ST_PAUSE) ? 2'd1 : st_q[1:0];
  assign stop      = (st_q != ST_PLAY);
  assign timer_run = (st_q == ST_SERVE) || (st_q == ST_PLAY);
  assign serve     = serve_q;
  assign scores    = score_q;
  assign winner    = winner_q;
  assign tie       = tie_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_match_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_match_fsm
//  Description : Directed self-checking bench for pong_match_fsm with a
//                2-player and a 3-player instance (SERVE_TICKS=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_match_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       time_up = 1'b0;
  logic       start2 = 1'b0;
  logic       start3 = 1'b0;
  logic [1:0] miss2 = '0;
  logic [2:0] miss3 = '0;

  logic [1:0]  state2, winner2, state3, winner3;
  logic        stop2, run2, serve2, tie2, stop3, run3, serve3, tie3;
  logic [7:0]  scores2;
  logic [11:0] scores3;

  int n_assert = 0;
  int n_fail   = 0;

  pong_match_fsm #(.NUM_PLAYERS(2), .SCORE_W(4), .WIN_SCORE(7), .SERVE_TICKS(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .tick(tick), .time_up(time_up), .miss(miss2),
    .state(state2), .stop(stop2), .timer_run(run2), .serve(serve2),
    .scores(scores2), .winner(winner2), .tie(tie2)
  );

  pong_match_fsm #(.NUM_PLAYERS(3), .SCORE_W(4), .WIN_SCORE(7), .SERVE_TICKS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .tick(tick), .time_up(1'b0), .miss(miss3),
    .state(state3), .stop(stop3), .timer_run(run3), .serve(serve3),
    .scores(scores3), .winner(winner3), .tie(tie3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press2();
    start2 = 1'b0; cyc();
    start2 = 1'b1; cyc();
    start2 = 1'b0;
  endtask

  task automatic press3();
    start3 = 1'b0; cyc();
    start3 = 1'b1; cyc();
    start3 = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  // Three ticks drain the counter, the following clock enters PLAY.
  task automatic serve_to_play();
    do_tick(); do_tick(); do_tick();
    cyc();
  endtask

  task automatic miss2_pulse(input logic [1:0] m);
    miss2 = m; cyc(); miss2 = '0;
  endtask

  task automatic miss3_pulse(input logic [2:0] m);
    miss3 = m; cyc(); miss3 = '0;
  endtask

  initial begin
    // Reset values
    cyc(); cyc();
    chk("rst_state", 32'(state2), 32'd0);
    chk("rst_stop", 32'(stop2), 32'd1);
    chk("rst_run", 32'(run2), 32'd0);
    chk("rst_serve", 32'(serve2), 32'd0);
    chk("rst_scores", 32'(scores2), 32'd0);
    chk("rst_winner", 32'(winner2), 32'd0);
    chk("rst_tie", 32'(tie2), 32'd0);
    rst = 1'b1;
    cyc();

    // Start -> SERVE, 3 ticks then PLAY with one serve pulse
    press2();
    chk("start_serve", 32'(state2), 32'd1);
    chk("serve_run", 32'(run2), 32'd1);
    chk("serve_stop", 32'(stop2), 32'd1);
    do_tick(); do_tick();
    chk("two_ticks_serve", 32'(state2), 32'd1);
    do_tick();
    chk("three_ticks_serve", 32'(state2), 32'd1);
    cyc();
    chk("play_state", 32'(state2), 32'd2);
    chk("play_serve_pulse", 32'(serve2), 32'd1);
    chk("play_stop", 32'(stop2), 32'd0);
    cyc();
    chk("serve_pulse_end", 32'(serve2), 32'd0);

    // Player 0 misses: player 1 scores, back to SERVE with counter reloaded
    miss2_pulse(2'b01);
    chk("miss01_scores", 32'(scores2), 32'h10);
    chk("miss01_state", 32'(state2), 32'd1);
    do_tick(); do_tick();
    chk("reload_serve", 32'(state2), 32'd1);
    do_tick(); cyc();
    chk("reload_play", 32'(state2), 32'd2);

    // Run player 1 up to 6
    for (int k = 0; k < 5; k++) begin
      miss2_pulse(2'b01);
      serve_to_play();
    end
    chk("p1_six", 32'(scores2), 32'h60);
    chk("p1_six_play", 32'(state2), 32'd2);
    miss2_pulse(2'b01);
    chk("win_scores", 32'(scores2), 32'h70);
    chk("win_state", 32'(state2), 32'd3);
    chk("win_winner", 32'(winner2), 32'd1);
    chk("win_tie", 32'(tie2), 32'd0);
    chk("over_stop", 32'(stop2), 32'd1);
    chk("over_run", 32'(run2), 32'd0);

    // OVER -> IDLE keeps scores, next start clears them
    press2();
    chk("idle_state", 32'(state2), 32'd0);
    chk("idle_scores_held", 32'(scores2), 32'h70);
    chk("idle_winner_clr", 32'(winner2), 32'd0);
    press2();
    chk("restart_state", 32'(state2), 32'd1);
    chk("restart_scores", 32'(scores2), 32'h00);

    // time_up during SERVE -> OVER, 0/0 is a shared top score
    time_up = 1'b1; cyc(); time_up = 1'b0;
    chk("tu_serve_state", 32'(state2), 32'd3);
    chk("tu_serve_winner", 32'(winner2), 32'd0);
    chk("tu_serve_tie", 32'(tie2), 32'd1);

    // Build 3/3, then time_up in PLAY
    press2(); press2();
    chk("new_match_serve", 32'(state2), 32'd1);
    for (int k = 0; k < 3; k++) begin
      serve_to_play();
      miss2_pulse(2'b01);
      serve_to_play();
      miss2_pulse(2'b10);
    end
    chk("three_all", 32'(scores2), 32'h33);
    serve_to_play();
    chk("three_all_play", 32'(state2), 32'd2);

`ifdef PONG_MATCH_PAUSE_EN
    press2();
    chk("pause_state", 32'(state2), 32'd1);
    chk("pause_stop", 32'(stop2), 32'd1);
    chk("pause_run", 32'(run2), 32'd0);
    do_tick(); do_tick(); do_tick(); do_tick(); cyc();
    chk("pause_hold", 32'(state2), 32'd1);
    press2();
    chk("resume_state", 32'(state2), 32'd2);
    chk("resume_no_serve", 32'(serve2), 32'd0);
`else
    press2();
    chk("start_ignored_play", 32'(state2), 32'd2);
    chk("start_ignored_stop", 32'(stop2), 32'd0);
`endif

    time_up = 1'b1; cyc(); time_up = 1'b0;
    chk("tu_play_state", 32'(state2), 32'd3);
    chk("tu_play_winner", 32'(winner2), 32'd0);
    chk("tu_play_tie", 32'(tie2), 32'd1);
    chk("tu_play_scores", 32'(scores2), 32'h33);

    // Three players: double miss voids the rally, single miss scores the others
    press3();
    chk("p3_serve", 32'(state3), 32'd1);
    serve_to_play();
    chk("p3_play", 32'(state3), 32'd2);
    miss3_pulse(3'b011);
    chk("p3_double_scores", 32'(scores3), 32'h000);
    chk("p3_double_state", 32'(state3), 32'd1);
    serve_to_play();
    // miss coinciding with tick is still handled
    tick = 1'b1;
    miss3_pulse(3'b100);
    tick = 1'b0;
    chk("p3_single_scores", 32'(scores3), 32'h011);
    chk("p3_single_state", 32'(state3), 32'd1);

    // Asynchronous reset mid-match takes effect without a clock edge
    #2 rst = 1'b0;
    #1;
    chk("async_rst_state2", 32'(state2), 32'd0);
    chk("async_rst_tie2", 32'(tie2), 32'd0);
    chk("async_rst_scores2", 32'(scores2), 32'd0);
    chk("async_rst_state3", 32'(state3), 32'd0);
    chk("async_rst_scores3", 32'(scores3), 32'd0);
    cyc();
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_match_fsm.md
Name: pong_match_fsm

Overview:
Parametrised match-flow controller for the Pong design. It generalises the 2-player game FSM to 2..4 players. It adds a first-to-WIN_SCORE end condition, a tick-driven serve delay, registered winner/tie reporting, and edge-detected start. It sits between the key-pad/timer blocks and the ball/paddle state machine, driving its stop input and feeding scores to the score display controllers.

Parameters:
NUM_PLAYERS, 2, number of players; legal range 2..4.
SCORE_W, 4, width of each per-player score counter.
WIN_SCORE, 7, score that ends the match; must be ≤ 2^SCORE_W-1.
SERVE_TICKS, 200, tick pulses spent in SERVE before play resumes (2 s at 100 Hz).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
start  input  1  start/continue button level, already synchronised; rising edge detected internally
tick  input  1  one-clk-wide pulse at 100 Hz
time_up  input  1  match countdown reached 0:00 (level)
miss  input  NUM_PLAYERS  bit i pulses one clk when player i misses the ball
state  output  2  0=IDLE 1=SERVE 2=PLAY 3=OVER
stop  output  1  high in every state except PLAY
timer_run  output  1  enables match countdown; high in SERVE and PLAY
serve  output  1  one-clk pulse on the SERVE->PLAY transition
scores  output  NUM_PLAYERS*SCORE_W  player i score at bits [i*SCORE_W +: SCORE_W]
winner  output  2  index of the winning player, valid in OVER
tie  output  1  high in OVER when two or more players share the top score

Behaviour:
- Reset, asynchronous, all registered: state=IDLE, scores=0, winner=0, tie=0, serve=0, serve counter=0, start edge register=0. Decoded outputs follow: stop=1, timer_run=0.
- start_edge = start & ~start_prev, with start_prev registered every clk.
- IDLE:
  - Scores hold their last values so the final result stays displayed.
  - On start_edge: clear all scores, load serve counter with SERVE_TICKS, go to SERVE.
- SERVE:
  - Counter decrements on each tick.
  - When the counter is 0, go to PLAY and assert serve for that one clk.
  - start is ignored.
  - time_up goes to OVER; it has priority over the counter.
  - miss is ignored.
- PLAY, priority order:
  - time_up -> OVER.
  - Exactly one miss bit i set -> every player j≠i gets +1, saturating at 2^SCORE_W-1. (With 2 players this is the classic "opponent scores".) If any updated score ≥ WIN_SCORE -> OVER; else reload the serve counter -> SERVE.
  - Two or more miss bits set in the same clk -> no points awarded; reload the serve counter -> SERVE.
  - No event -> stay in PLAY.
- Entry to OVER:
  - winner and tie are registered in the same clk the state changes, computed from the post-update scores.
  - winner = lowest index holding the maximum score.
  - tie = 1 if that maximum is held by more than one player.
- OVER:
  - winner and tie hold.
  - start_edge -> IDLE, with winner and tie cleared to 0.
- Latency:
  - A score change is visible one clk after the miss pulse.
  - state updates on the same edge.
- The tick and miss pulses may coincide; both are handled in that clk.
- A reset asserted mid-match returns everything to the reset values immediately.
- Any unused state encoding recovers to IDLE.

Optional Feature:
Macro PONG_MATCH_PAUSE_EN.
- Defined:
  - start_edge in PLAY enters a PAUSE hold, reported as state=1, with stop=1 and timer_run=0.
  - The serve counter is not touched.
  - The next start_edge returns to PLAY without a serve pulse.
  - time_up during PAUSE still goes to OVER.
- Undefined: start is ignored in PLAY, and no PAUSE hold exists.

Test Plan:
- Reset, then start rising edge with NUM_PLAYERS=2 and SERVE_TICKS=3 -> state SERVE; after exactly 3 ticks state PLAY with one serve pulse; stop=0.
- In PLAY, miss=2'b01 -> next clk scores=player1:1, player0:0; state SERVE; counter reloaded.
- Drive player1 to 6, then miss=2'b01 in PLAY -> score 7, state OVER, winner=1, tie=0; start edge -> IDLE with scores still 0/7; next start edge clears scores.
- NUM_PLAYERS=3 with miss=3'b011 in PLAY -> no score change, state SERVE. Then miss=3'b100 -> players 0 and 1 each +1.
- time_up asserted in PLAY with scores 3/3 -> OVER, winner=0, tie=1. Also assert time_up during SERVE -> OVER.
- With PONG_MATCH_PAUSE_EN: start edge in PLAY -> stop=1, timer_run=0; ticks do not change the counter; second edge -> PLAY, no serve pulse.
